// File: rtl/nrisc_pkg.sv
// Shared nRisc encoding constants, field layouts and control types for the program loader.
package nrisc_pkg;

    localparam int unsigned OP_W        = 3;
    localparam int unsigned REG_W       = 2;
    localparam int unsigned IMM_W       = 8;
    localparam int unsigned WORD_W      = 8;
    localparam int unsigned IMM_W_MEM   = 3;
    localparam int unsigned IMM_W_ARIT  = 4;
    localparam int unsigned IMM_W_SALTO = 5;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_STORE = 3'b000;
    localparam opcode_t OP_LA    = 3'b001;
    localparam opcode_t OP_LOAD  = 3'b010;
    localparam opcode_t OP_R0    = 3'b011;
    localparam opcode_t OP_ADDI  = 3'b100;
    localparam opcode_t OP_BEQ   = 3'b101;
    localparam opcode_t OP_J     = 3'b110;
    localparam opcode_t OP_R1    = 3'b111;

    typedef enum logic [1:0] {
        ERR_NENHUM = 2'b00,
        ERR_FAIXA  = 2'b01,
        ERR_CHEIO  = 2'b10
    } erro_t;

    typedef enum logic [2:0] {
        OCIOSO,
        CODIFICA,
        ESCREVE,
        CONCLUIDO,
        CHEIO
    } estado_t;

    typedef struct packed {
        opcode_t            opcode;
        logic [REG_W-1:0]   reg_a;
        logic [REG_W-1:0]   reg_b;
        logic               funct;
        logic [IMM_W-1:0]   imm;
        logic               last;
    } campos_t;

endpackage

// File: rtl/montador_de_programa_if.sv
// Field-bundle valid/ready channel from the boot loader into the program assembler.
interface montador_de_programa_if;
    import nrisc_pkg::*;

    logic             in_valid;
    logic             in_ready;
    opcode_t          in_opcode;
    logic [REG_W-1:0] in_reg_a;
    logic [REG_W-1:0] in_reg_b;
    logic             in_funct;
    logic [IMM_W-1:0] in_imm;
    logic             in_last;

    modport master (
        output in_valid, in_opcode, in_reg_a, in_reg_b, in_funct, in_imm, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_reg_a, in_reg_b, in_funct, in_imm, in_last,
        output in_ready
    );

endinterface

// File: rtl/codificador_de_instrucao.sv
// Packs decoded nRisc fields into an 8-bit word and flags immediates that do not fit.
module codificador_de_instrucao
    import nrisc_pkg::*;
(
    input  opcode_t           opcode,
    input  logic [REG_W-1:0]  reg_a,
    input  logic [REG_W-1:0]  reg_b,
    input  logic              funct,
    input  logic [IMM_W-1:0]  imm,
    output logic [WORD_W-1:0] word,
    output logic              fora_de_faixa
);

    always_comb begin
        word          = '0;
        fora_de_faixa = 1'b0;
        case (opcode)
            OP_STORE, OP_LOAD: begin
                word          = {opcode, reg_a, imm[IMM_W_MEM-1:0]};
                fora_de_faixa = |imm[IMM_W-1:IMM_W_MEM];
            end
            OP_LA, OP_ADDI: begin
                // Only one register bit fits, so r2/r3 are unreachable here.
                word          = {opcode, reg_a[0], imm[IMM_W_ARIT-1:0]};
                fora_de_faixa = (|imm[IMM_W-1:IMM_W_ARIT]) | reg_a[1];
            end
            OP_BEQ, OP_J: begin
                word          = {opcode, imm[IMM_W_SALTO-1:0]};
                fora_de_faixa = |imm[IMM_W-1:IMM_W_SALTO];
            end
            default: begin
                word          = {opcode, reg_a, reg_b, funct};
                fora_de_faixa = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/montador_de_programa.sv
// Accepts field bundles, encodes them and writes the words sequentially into instruction memory.
module montador_de_programa
    import nrisc_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                clock,
    input  logic                reset,
    montador_de_programa_if.slave in_if,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_data,
    output logic [ADDR_W:0]     count,
    output logic                done,
    output logic                erro,
    output logic [1:0]          erro_codigo
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    estado_t             estado_q, estado_d;
    campos_t             cap_q, cap_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_data_q, mem_data_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                done_q, done_d;
    logic                erro_q, erro_d;
    erro_t               erro_cod_q, erro_cod_d;

    logic [WORD_W-1:0]   enc_word;
    logic                enc_err;

    codificador_de_instrucao u_codificador (
        .opcode        (cap_q.opcode),
        .reg_a         (cap_q.reg_a),
        .reg_b         (cap_q.reg_b),
        .funct         (cap_q.funct),
        .imm           (cap_q.imm),
        .word          (enc_word),
        .fora_de_faixa (enc_err)
    );

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            cap_q      <= '0;
            in_ready_q <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            erro_q     <= 1'b0;
            erro_cod_q <= ERR_NENHUM;
        end else begin
            estado_q   <= estado_d;
            cap_q      <= cap_d;
            in_ready_q <= in_ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            count_q    <= count_d;
            done_q     <= done_d;
            erro_q     <= erro_d;
            erro_cod_q <= erro_cod_d;
        end
    end

    // Next state; the write strobe is the only value that does not hold by default.
    always_comb begin
        estado_d   = estado_q;
        cap_d      = cap_q;
        in_ready_d = in_ready_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        count_d    = count_q;
        done_d     = done_q;
        erro_d     = erro_q;
        erro_cod_d = erro_cod_q;

        case (estado_q)
            OCIOSO: begin
                if (in_if.in_valid && in_ready_q) begin
                    cap_d = '{opcode: in_if.in_opcode,
                              reg_a:  in_if.in_reg_a,
                              reg_b:  in_if.in_reg_b,
                              funct:  in_if.in_funct,
                              imm:    in_if.in_imm,
                              last:   in_if.in_last};
                    estado_d   = CODIFICA;
                    in_ready_d = 1'b0;
                end
            end
            CODIFICA: begin
                if (enc_err) begin
                    erro_d     = 1'b1;
                    erro_cod_d = ERR_FAIXA;
                    estado_d   = OCIOSO;
                    in_ready_d = 1'b1;
                end else begin
                    mem_data_d = enc_word;
                    mem_we_d   = 1'b1;
                    estado_d   = ESCREVE;
                end
            end
            ESCREVE: begin
                count_d = count_q + (ADDR_W+1)'(1);
                // Address saturates on the last slot so it can never wrap.
                if (count_d != DEPTH_C) begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
                if (cap_q.last) begin
                    estado_d = CONCLUIDO;
                    done_d   = 1'b1;
                end else if (count_d == DEPTH_C) begin
                    estado_d   = CHEIO;
                    erro_d     = 1'b1;
                    erro_cod_d = ERR_CHEIO;
                end else begin
                    estado_d   = OCIOSO;
                    in_ready_d = 1'b1;
                end
            end
            CONCLUIDO, CHEIO: begin
                estado_d = estado_q;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign in_if.in_ready = in_ready_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_data       = mem_data_q;
    assign count          = count_q;
    assign done           = done_q;
    assign erro           = erro_q;
    assign erro_codigo    = erro_cod_q;

endmodule

// File: tb/tb_montador_de_programa.sv
// Directed bench for the program assembler: DEPTH=4 main instance with a write scoreboard, DEPTH=3 side instance.
module tb_montador_de_programa;
    import nrisc_pkg::*;

    localparam int unsigned ADDR_W = 5;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } escrita_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       v_valid;
    logic [2:0] v_op;
    logic [1:0] v_ra, v_rb;
    logic       v_fn;
    logic [7:0] v_imm;
    logic       v_last;

    montador_de_programa_if if4();
    montador_de_programa_if if3();

    assign if4.in_valid  = v_valid;
    assign if4.in_opcode = v_op;
    assign if4.in_reg_a  = v_ra;
    assign if4.in_reg_b  = v_rb;
    assign if4.in_funct  = v_fn;
    assign if4.in_imm    = v_imm;
    assign if4.in_last   = v_last;
    assign if3.in_valid  = v_valid;
    assign if3.in_opcode = v_op;
    assign if3.in_reg_a  = v_ra;
    assign if3.in_reg_b  = v_rb;
    assign if3.in_funct  = v_fn;
    assign if3.in_imm    = v_imm;
    assign if3.in_last   = v_last;

    logic              w4_we, w3_we;
    logic [ADDR_W-1:0] w4_addr, w3_addr;
    logic [7:0]        w4_data, w3_data;
    logic [ADDR_W:0]   w4_count, w3_count;
    logic              w4_done, w3_done, w4_erro, w3_erro;
    logic [1:0]        w4_cod, w3_cod;

    montador_de_programa #(.ADDR_W(ADDR_W), .DEPTH(4)) u_dut4 (
        .clock(clock), .reset(reset), .in_if(if4.slave),
        .mem_we(w4_we), .mem_addr(w4_addr), .mem_data(w4_data), .count(w4_count),
        .done(w4_done), .erro(w4_erro), .erro_codigo(w4_cod)
    );

    montador_de_programa #(.ADDR_W(ADDR_W), .DEPTH(3)) u_dut3 (
        .clock(clock), .reset(reset), .in_if(if3.slave),
        .mem_we(w3_we), .mem_addr(w3_addr), .mem_data(w3_data), .count(w3_count),
        .done(w3_done), .erro(w3_erro), .erro_codigo(w3_cod)
    );

    escrita_t          sb[$];
    int                checks   = 0;
    int                failures = 0;
    logic [ADDR_W-1:0] exp_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every strobe on the main instance must match the oldest expected write.
    always @(negedge clock) begin
        if (w4_we === 1'b1) begin
            escrita_t e;
            chk("write_expected", 32'(sb.size() != 0), 32'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("write_addr", 32'(w4_addr), 32'(e.addr));
                chk("write_data", 32'(w4_data), 32'(e.data));
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b1;
        v_valid = 1'b0;
        @(negedge clock);
        reset    = 1'b0;
        sb.delete();
        exp_addr = '0;
    endtask

    task automatic send(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                        input logic fn, input logic [7:0] imm, input logic last,
                        input logic [7:0] exp_word, input logic exp_err);
        int n = 0;
        @(negedge clock);
        v_op = op; v_ra = ra; v_rb = rb; v_fn = fn; v_imm = imm; v_last = last;
        v_valid = 1'b1;
        while (if4.in_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) begin
            chk("handshake_timeout", 32'(if4.in_ready), 32'(1));
        end else begin
            @(posedge clock);
            #1;
            if (!exp_err) begin
                sb.push_back('{addr: exp_addr, data: exp_word});
                exp_addr = exp_addr + ADDR_W'(1);
            end
        end
        v_valid = 1'b0;
    endtask

    task automatic idle();
        repeat (3) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; v_valid = 1'b0; v_op = '0; v_ra = '0; v_rb = '0;
        v_fn = 1'b0; v_imm = '0; v_last = 1'b0; exp_addr = '0;
        repeat (2) @(negedge clock);
        chk("rst_ready4", 32'(if4.in_ready), 32'(1));
        chk("rst_we4",    32'(w4_we),    32'(0));
        chk("rst_addr4",  32'(w4_addr),  32'(0));
        chk("rst_data4",  32'(w4_data),  32'(0));
        chk("rst_count4", 32'(w4_count), 32'(0));
        chk("rst_done4",  32'(w4_done),  32'(0));
        chk("rst_erro4",  32'(w4_erro),  32'(0));
        chk("rst_cod4",   32'(w4_cod),   32'(0));
        chk("rst_ready3", 32'(if3.in_ready), 32'(1));
        chk("rst_vec3",   32'({w3_we, w3_addr, w3_data, w3_count, w3_done, w3_erro, w3_cod}), 32'(0));
        reset = 1'b0;

        // store r2,5: strobe exactly two cycles after the handshake
        send(OP_STORE, 2'd2, 2'd0, 1'b0, 8'd5, 1'b0, 8'h15, 1'b0);
        @(negedge clock);
        chk("lat_codifica_we", 32'(w4_we), 32'(0));
        chk("lat_codifica_ready", 32'(if4.in_ready), 32'(0));
        @(negedge clock);
        chk("lat_escreve_we", 32'(w4_we), 32'(1));
        chk("lat_escreve_count", 32'(w4_count), 32'(0));
        @(negedge clock);
        chk("lat_after_we", 32'(w4_we), 32'(0));
        chk("lat_after_count", 32'(w4_count), 32'(1));
        chk("lat_after_addr", 32'(w4_addr), 32'(1));
        chk("lat_after_ready", 32'(if4.in_ready), 32'(1));

        // addi, j, beq in sequence
        do_reset();
        send(OP_ADDI, 2'd1, 2'd0, 1'b0, 8'd9,    1'b0, 8'h99, 1'b0);
        send(OP_J,    2'd3, 2'd3, 1'b1, 8'h1F,   1'b0, 8'hDF, 1'b0);
        send(OP_BEQ,  2'd0, 2'd0, 1'b0, 8'd3,    1'b0, 8'hA3, 1'b0);
        idle();
        chk("seq_count", 32'(w4_count), 32'(3));
        chk("seq_erro",  32'(w4_erro),  32'(0));

        // range errors and recovery
        do_reset();
        send(OP_LOAD, 2'd0, 2'd0, 1'b0, 8'd8, 1'b0, 8'h00, 1'b1);
        idle();
        chk("rng_erro",  32'(w4_erro),  32'(1));
        chk("rng_cod",   32'(w4_cod),   32'(1));
        chk("rng_count", 32'(w4_count), 32'(0));
        send(OP_R0, 2'd1, 2'd2, 1'b1, 8'hFF, 1'b0, 8'h6D, 1'b0);
        idle();
        chk("rtype_count", 32'(w4_count), 32'(1));
        chk("rtype_erro_sticky", 32'(w4_erro), 32'(1));
        send(OP_LA,   2'd2, 2'd0, 1'b0, 8'd1,  1'b0, 8'h00, 1'b1);
        send(OP_ADDI, 2'd0, 2'd0, 1'b0, 8'd16, 1'b0, 8'h00, 1'b1);
        send(OP_BEQ,  2'd0, 2'd0, 1'b0, 8'd32, 1'b0, 8'h00, 1'b1);
        idle();
        chk("rng2_count", 32'(w4_count), 32'(1));
        chk("rng2_cod",   32'(w4_cod),   32'(1));
        chk("rng2_ready", 32'(if4.in_ready), 32'(1));

        // fill DEPTH=4 without in_last
        do_reset();
        for (int i = 0; i < 4; i++)
            send(OP_STORE, 2'd1, 2'd0, 1'b0, 8'(i), 1'b0, 8'(8'h08 + i), 1'b0);
        idle();
        chk("full_ready", 32'(if4.in_ready), 32'(0));
        chk("full_erro",  32'(w4_erro),  32'(1));
        chk("full_cod",   32'(w4_cod),   32'(2));
        chk("full_count", 32'(w4_count), 32'(4));
        chk("full_done",  32'(w4_done),  32'(0));
        chk("full3_cod",   32'(w3_cod),   32'(2));
        chk("full3_count", 32'(w3_count), 32'(3));
        @(negedge clock);
        v_op = OP_STORE; v_imm = 8'd1; v_last = 1'b0; v_valid = 1'b1;
        repeat (6) @(negedge clock);
        v_valid = 1'b0;
        chk("full_5th_count", 32'(w4_count), 32'(4));

        // in_last on the third word; DEPTH=3 finishes cleanly too
        do_reset();
        send(OP_LOAD, 2'd3, 2'd0, 1'b0, 8'd7, 1'b0, 8'h5F, 1'b0);
        send(OP_LA,   2'd1, 2'd0, 1'b0, 8'd15, 1'b0, 8'h3F, 1'b0);
        send(OP_R1,   2'd2, 2'd1, 1'b0, 8'd0, 1'b1, 8'hF2, 1'b0);
        idle();
        chk("last_done",  32'(w4_done),  32'(1));
        chk("last_count", 32'(w4_count), 32'(3));
        chk("last_ready", 32'(if4.in_ready), 32'(0));
        chk("last_erro",  32'(w4_erro),  32'(0));
        chk("last3_done",  32'(w3_done),  32'(1));
        chk("last3_erro",  32'(w3_erro),  32'(0));
        chk("last3_count", 32'(w3_count), 32'(3));
        chk("last3_cod",   32'(w3_cod),   32'(0));

        // reset while the strobe is high
        do_reset();
        send(OP_STORE, 2'd0, 2'd0, 1'b0, 8'd1, 1'b0, 8'h01, 1'b0);
        @(negedge clock);
        @(negedge clock);
        chk("midw_we_before", 32'(w4_we), 32'(1));
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midw_we",    32'(w4_we),    32'(0));
        chk("midw_addr",  32'(w4_addr),  32'(0));
        chk("midw_count", 32'(w4_count), 32'(0));
        chk("midw_ready", 32'(if4.in_ready), 32'(1));
        reset = 1'b0;
        idle();

        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
